// File: rtl/chess_mv_pkg.sv
// ----------------------------------------------------------------------------
// chess_mv_pkg
//   Shared definitions for the legal-move-generator output path: the packed
//   move-word layout, move field offsets, the invalid-move marker, the
//   unpacker FSM states and slot helper functions.
//   Move word (160 b): [159:152] pad, slot0 = [151:133] ... slot7 = [18:0].
//   Move slot (19 b):  {flags[6:0], from[5:0], to[5:0]}.
// ----------------------------------------------------------------------------
package chess_mv_pkg;

    localparam int unsigned MV_W       = 19;
    localparam int unsigned MV_SLOTS   = 8;
    localparam int unsigned MVWORD_W   = 160;
    localparam int unsigned PAD_W      = MVWORD_W - MV_SLOTS * MV_W;
    localparam int unsigned SLOT_IDX_W = 3;

    localparam int unsigned TO_LSB     = 0;
    localparam int unsigned FROM_LSB   = 6;
    localparam int unsigned FLG_LSB    = 12;
    localparam int unsigned SQ_W       = 6;
    localparam int unsigned FLG_W      = 7;
    localparam int unsigned INV_BIT    = 6;

    localparam logic [FLG_W-1:0] IMOV = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } unpack_state_e;

    // Slot 0 sits at the top of the slot field, slot 7 at the bottom.
    function automatic logic [MV_W-1:0] slot_extract(
        input logic [MV_SLOTS*MV_W-1:0] slots,
        input logic [SLOT_IDX_W-1:0]    idx
    );
        return slots[(MV_SLOTS - 1 - 32'(idx)) * MV_W +: MV_W];
    endfunction

    function automatic logic slot_invalid(input logic [MV_W-1:0] mv);
        return (mv[FLG_LSB +: FLG_W] & IMOV) != '0;
    endfunction

    function automatic logic slot_self_move(input logic [MV_W-1:0] mv);
        return !mv[FLG_LSB + INV_BIT] &&
               (mv[FROM_LSB +: SQ_W] == mv[TO_LSB +: SQ_W]);
    endfunction

endpackage

// File: rtl/mv_slot_pick.sv
// ----------------------------------------------------------------------------
// mv_slot_pick
//   Combinational priority pick over the pending-slot mask: lowest set bit
//   wins, so slot 0 is emitted first.
//   mask in  [7:0]  pending (legal, not yet transferred) slots
//   idx  out [2:0]  index of lowest set mask bit (0 when mask is empty)
//   any  out        mask has at least one bit set
// ----------------------------------------------------------------------------
module mv_slot_pick
    import chess_mv_pkg::*;
(
    input  logic [MV_SLOTS-1:0]   mask,
    output logic [SLOT_IDX_W-1:0] idx,
    output logic                  any
);

    // Scan high to low so the last hit is the lowest index.
    always_comb begin
        idx = '0;
        for (int unsigned i = MV_SLOTS; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = SLOT_IDX_W'(i - 1);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/lmg_move_unpacker.sv
// ----------------------------------------------------------------------------
// lmg_move_unpacker
//   Drains the legal-move-generator FIFO one 160-bit word at a time, drops
//   slots flagged invalid (flags[6]) and streams the legal moves one per
//   valid/ready handshake. Reports a saturating move count and a done level
//   once the generator has finished and the FIFO is empty.
//   Optional feature macro: UNPACK_ERRCHK_EN -- sticky err on a captured word
//   with non-zero pad or any legal slot with from == to.
//
//   clk       in         rising-edge clock
//   reset     in         asynchronous, active-low
//   start     in         begins a drain (accepted in IDLE/DONE only)
//   lmg_done  in         generator finished writing (level)
//   fifoIn    in  [159:0] FIFO read data
//   fifoEmpty in         FIFO empty flag
//   rden      out        FIFO read request, one pulse per word
//   mv_out    out [18:0] current move {flags, from, to}
//   mv_valid  out        mv_out valid, held until accepted
//   mv_ready  in         downstream accept
//   mv_count  out [CNT_W-1:0] moves transferred since start (saturating)
//   done      out        drain complete
//   err       out        sticky protocol error (0 unless UNPACK_ERRCHK_EN)
// ----------------------------------------------------------------------------
module lmg_move_unpacker
    import chess_mv_pkg::*;
#(
    parameter int unsigned FIFO_LAT = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                lmg_done,
    input  logic [MVWORD_W-1:0] fifoIn,
    input  logic                fifoEmpty,
    output logic                rden,
    output logic [MV_W-1:0]     mv_out,
    output logic                mv_valid,
    input  logic                mv_ready,
    output logic [CNT_W-1:0]    mv_count,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] LAT_LAST = 2'(FIFO_LAT - 1);

    unpack_state_e              state_q, state_d;
    logic [MV_SLOTS*MV_W-1:0]   word_q, word_d;
    logic [MV_SLOTS-1:0]        mask_q, mask_d;
    logic [1:0]                 lat_q, lat_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic [MV_SLOTS*MV_W-1:0]   slots_in;
    logic [SLOT_IDX_W-1:0]      pick_idx;
    logic                       pick_any;
    logic [MV_SLOTS-1:0]        pick_oh;
    logic                       xfer;
    logic                       start_ok;
    logic                       capture;

    mv_slot_pick u_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign slots_in = fifoIn[MV_SLOTS*MV_W-1:0];
    assign pick_oh  = MV_SLOTS'(1) << pick_idx;
    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign capture  = (state_q == ST_WAIT) && (lat_q == LAT_LAST);
    assign xfer     = (state_q == ST_EMIT) && pick_any && mv_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        rden    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                // lmg_done only matters once the FIFO is empty, so words
                // written before it rose are still drained.
                if (!fifoEmpty) begin
                    rden    = 1'b1;
                    lat_d   = '0;
                    state_d = ST_WAIT;
                end else if (lmg_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    word_d = slots_in;
                    for (int unsigned i = 0; i < MV_SLOTS; i++) begin
                        mask_d[i] = !slot_invalid(slot_extract(slots_in, SLOT_IDX_W'(i)));
                    end
                    state_d = ST_EMIT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_EMIT: begin
                if (!pick_any) begin
                    state_d = ST_REQ;
                end else if (xfer) begin
                    mask_d = mask_q & ~pick_oh;
                    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    if (mask_d == '0) begin
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            mask_q  <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mv_valid = (state_q == ST_EMIT) && pick_any;
    assign mv_out   = mv_valid ? slot_extract(word_q, pick_idx) : '0;
    assign mv_count = cnt_q;
    assign done     = (state_q == ST_DONE);

`ifdef UNPACK_ERRCHK_EN
    logic err_q, err_d, cap_err;

    always_comb begin
        cap_err = (fifoIn[MVWORD_W-1 -: PAD_W] != '0);
        for (int unsigned i = 0; i < MV_SLOTS; i++) begin
            if (slot_self_move(slot_extract(slots_in, SLOT_IDX_W'(i)))) begin
                cap_err = 1'b1;
            end
        end
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (capture) begin
            err_d = err_q | cap_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_pad;
    assign unused_pad = ^fifoIn[MVWORD_W-1 -: PAD_W];
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_lmg_move_unpacker.sv
module tb_lmg_move_unpacker;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         lmg_done = 1'b0;
    logic [159:0] fifoIn;
    logic         fifoEmpty;
    logic         rden;
    logic [18:0]  mv_out;
    logic         mv_valid;
    logic         mv_ready = 1'b0;
    logic [7:0]   mv_count;
    logic         done;
    logic         err;

    lmg_move_unpacker #(.FIFO_LAT(1), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lmg_done  (lmg_done),
        .fifoIn    (fifoIn),
        .fifoEmpty (fifoEmpty),
        .rden      (rden),
        .mv_out    (mv_out),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .mv_count  (mv_count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // FIFO model, normal mode: q updates on the edge that sees rdreq.
    logic [159:0] mem [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign fifoEmpty = (wr_cnt == rd_cnt);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt <= 0;
            fifoIn <= '0;
        end else if (rden) begin
            fifoIn <= mem[rd_cnt % 64];
            rd_cnt <= rd_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [18:0] expq[$];
    logic [18:0] mlog[$];

    function automatic logic [18:0] mk(input logic [6:0] f, input logic [5:0] fr, input logic [5:0] to);
        return {f, fr, to};
    endfunction

    task automatic mkword(input logic [7:0] pad, input int kind, output logic [159:0] w);
        logic [18:0] s;
        w = '0;
        w[159:152] = pad;
        for (int i = 0; i < 8; i++) begin
            case (kind)
                1: s = mk(7'h00, 6'(8*i + 1), 6'(8*i + 2));
                2: case (i)
                       0: s = mk(7'h00, 6'o10, 6'o02);
                       1: s = mk(7'h00, 6'o10, 6'o22);
                       2: s = mk(7'h00, 6'o60, 6'o52);
                       3: s = mk(7'h00, 6'o60, 6'o72);
                       default: s = mk(7'h40, 6'o00, 6'o00);
                   endcase
                3: s = mk(7'h40, 6'(i), 6'(i + 1));
                4: s = mk(7'h05, 6'(i), 6'(i + 8));
                default: s = mk(7'h3F, 6'(63 - i), 6'(i));
            endcase
            w[151 - 19*i -: 19] = s;
        end
    endtask

    task automatic push_word(input logic [159:0] w);
        logic [18:0] s;
        mem[wr_cnt % 64] = w;
        for (int i = 0; i < 8; i++) begin
            s = w[151 - 19*i -: 19];
            if (!s[18]) expq.push_back(s);
        end
        wr_cnt++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; pat 0 = always ready, 1 = ready pattern 1-0-0-1.
    task automatic drain(input int n, input int pat, input int budget,
                         output int t_rden, output int t_v0, output int t_vl);
        int got = 0;
        int cyc = 0;
        int pi = 0;
        logic stall = 1'b0;
        logic [18:0] held = '0;
        logic r;
        t_rden = -1; t_v0 = -1; t_vl = -1;
        mlog.delete();
        while (got < n && cyc < budget) begin
            if (rden && t_rden < 0) t_rden = cyc;
            if (stall) begin
                chk("stall_valid", 32'(mv_valid), 1);
                chk("stall_hold", 32'(mv_out), 32'(held));
            end
            r = (pat == 0) || (pi % 4 == 0) || (pi % 4 == 3);
            mv_ready = r;
            stall = 1'b0;
            if (mv_valid) begin
                if (t_v0 < 0) t_v0 = cyc;
                pi++;
                if (r) begin
                    chk("exp_avail", 32'(expq.size() > 0), 1);
                    if (expq.size() > 0) chk("move", 32'(mv_out), 32'(expq.pop_front()));
                    mlog.push_back(mv_out);
                    got++;
                    t_vl = cyc;
                end else begin
                    stall = 1'b1;
                    held = mv_out;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mv_ready = 1'b0;
        chk("drain_count", got, n);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("done", 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, nv;
        logic [159:0] w;
        logic exp_err;

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rden", 32'(rden), 0);
        chk("rst_valid", 32'(mv_valid), 0);
        chk("rst_mv_out", 32'(mv_out), 0);
        chk("rst_count", 32'(mv_count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: eight pawn moves, ready always high
        mkword(8'h00, 1, w); push_word(w);
        pulse_start();
        drain(8, 0, 40, a, b, c);
        chk("t1_first", 32'(mlog[0]), 32'h00042);
        chk("t1_last", 32'(mlog[7]), 32'h00E7A);
        chk("t1_latency", b - a, 2);
        chk("t1_b2b", c - b, 7);
        chk("t1_count", 32'(mv_count), 8);

        // 2: four legal slots, then the next word is requested right away
        mkword(8'h00, 2, w); push_word(w);
        mkword(8'h00, 3, w); push_word(w);
        drain(4, 0, 40, a, b, c);
        chk("t2_first", 32'(mlog[0]), 32'h00202);
        chk("t2_last", 32'(mlog[3]), 32'h00C3A);
        chk("t2_next_rden", 32'(rden), 1);
        chk("t2_count", 32'(mv_count), 12);

        // 3: all-invalid word produces nothing, then done
        nv = 0;
        repeat (8) begin
            if (mv_valid) nv++;
            @(negedge clk);
        end
        chk("t3_no_valid", nv, 0);
        chk("t3_fifo_empty", 32'(fifoEmpty), 1);
        lmg_done = 1'b1;
        wait_done();
        chk("t3_count", 32'(mv_count), 12);

        // 4: stalled handshake
        lmg_done = 1'b0;
        mkword(8'h00, 1, w); push_word(w);
        pulse_start();
        chk("t4_count_clr", 32'(mv_count), 0);
        chk("t4_done_clr", 32'(done), 0);
        drain(8, 1, 80, a, b, c);
        chk("t4_count", 32'(mv_count), 8);

        // 5: three words, lmg_done raised after the second write
        mkword(8'h00, 1, w); push_word(w);
        mkword(8'h00, 4, w); push_word(w);
        lmg_done = 1'b1;
        mkword(8'h00, 5, w); push_word(w);
        drain(24, 0, 120, a, b, c);
        wait_done();
        chk("t5_count", 32'(mv_count), 32);
        pulse_start();
        chk("t5_count_clr", 32'(mv_count), 0);

        // 6: reset mid-emit
        lmg_done = 1'b0;
        mkword(8'h00, 1, w); push_word(w);
        drain(3, 0, 40, a, b, c);
        chk("t6_valid", 32'(mv_valid), 1);
        chk("t6_count", 32'(mv_count), 3);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(mv_valid), 0);
        chk("t6_rst_mv_out", 32'(mv_out), 0);
        chk("t6_rst_count", 32'(mv_count), 0);
        chk("t6_rst_rden", 32'(rden), 0);
        chk("t6_rst_done", 32'(done), 0);
        expq.delete();
        wr_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 7: non-zero pad
`ifdef UNPACK_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        mkword(8'h01, 1, w); push_word(w);
        pulse_start();
        drain(8, 0, 40, a, b, c);
        chk("t7_err", 32'(err), 32'(exp_err));
        chk("t7_count", 32'(mv_count), 8);
        lmg_done = 1'b1;
        wait_done();
        pulse_start();
        chk("t7_err_clr", 32'(err), 0);

        // 8: count saturates at 255 (264 legal moves)
        lmg_done = 1'b0;
        for (int k = 0; k < 33; k++) begin
            mkword(8'h00, 4, w); push_word(w);
        end
        drain(264, 0, 33*14, a, b, c);
        chk("t8_sat", 32'(mv_count), 255);
        lmg_done = 1'b1;
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
